// File: rtl/attn_pkg.sv
// attn_pkg: shared state encoding and widths for the attention head scheduler.
package attn_pkg;
  localparam int SCORE_W = 32;
  localparam int HEAD_W = 2;
  localparam int DEF_NUM_HEADS = 4;
  localparam int DEF_SCORES_PER_HEAD = 16;
  typedef enum logic [3:0] {
    IDLE,
    SCORE_GO,
    SCORE_WAIT,
    LD_ADDR,
    LD_CAP,
    SCALE_GO,
    SCALE_WAIT,
    SM_GO,
    SM_FEED,
    SM_WAIT,
    GEMM_GO,
    GEMM_WAIT,
    NEXT_HEAD,
    DONE
  } sched_state_t;
endpackage

// File: rtl/attn_sched_wdt.sv
// attn_sched_wdt: per-wait-state cycle watchdog; only present when ATTN_SCHED_WDT_EN is defined.
`ifdef ATTN_SCHED_WDT_EN
module attn_sched_wdt #(
  parameter int TIMEOUT = 4096
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic hit
);
  localparam int W = $clog2(TIMEOUT + 1);
  logic [W-1:0] cnt;
  // every wait state is entered from a non-wait state, so clearing while idle restarts it on entry
  always_ff @(posedge clk) begin
    if (!rst_n) cnt <= '0;
    else cnt <= run ? cnt + 1'b1 : '0;
  end
  assign hit = run && cnt == W'(TIMEOUT - 1);
endmodule
`endif

// File: rtl/attn_head_sched.sv
// attn_head_sched: sequences score, scale, softmax and GEMM engines across all heads.
// Optional wait-state watchdog with sticky err enabled by ATTN_SCHED_WDT_EN.
module attn_head_sched
  import attn_pkg::*;
#(
  parameter int NUM_HEADS = DEF_NUM_HEADS,
  parameter int SCORES_PER_HEAD = DEF_SCORES_PER_HEAD,
  parameter int TIMEOUT = 4096
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      start,
  input  logic                                      abort,
  output logic                                      score_start,
  input  logic                                      score_done,
  output logic                                      score_rd_en,
  output logic [HEAD_W+3:0]                         score_rd_addr,
  input  logic [SCORE_W-1:0]                        score_rd_data,
  output logic                                      scale_start,
  input  logic                                      scale_done,
  output logic [DEF_SCORES_PER_HEAD*SCORE_W-1:0]    score_head_flat,
  output logic                                      sm_start,
  output logic [1:0]                                sm_col,
  output logic                                      sm_feed,
  input  logic [3:0]                                sm_done,
  output logic                                      gemm_start,
  input  logic                                      gemm_done,
  output logic [HEAD_W-1:0]                         head_sel,
  output logic                                      busy,
  output logic                                      done,
  output logic                                      err
);
  if (NUM_HEADS < 1 || NUM_HEADS > 4 || SCORES_PER_HEAD < 1 || SCORES_PER_HEAD > 16 || TIMEOUT < 2) begin : g_bad_cfg
    $error("attn_head_sched: parameter out of range");
  end
  sched_state_t state, next;
  logic start_d, start_pulse, accept, last_idx, last_head;
  logic [3:0] idx, mask;
  logic [1:0] col;
  logic [DEF_SCORES_PER_HEAD*SCORE_W-1:0] cap, cap_nx;
  assign start_pulse = start & ~start_d;
  assign accept = state == IDLE && start_pulse && !abort;
  assign last_idx = idx == 4'(SCORES_PER_HEAD - 1);
  assign last_head = head_sel == HEAD_W'(NUM_HEADS - 1);
`ifdef ATTN_SCHED_WDT_EN
  logic in_wait, wdt_hit;
  assign in_wait = state == SCORE_WAIT || state == SCALE_WAIT || state == SM_WAIT || state == GEMM_WAIT;
  attn_sched_wdt #(.TIMEOUT(TIMEOUT)) u_wdt (
    .clk(clk),
    .rst_n(rst_n),
    .run(in_wait),
    .hit(wdt_hit)
  );
  // abort leaves err untouched; a fresh accepted start clears it
  always_ff @(posedge clk) begin
    if (!rst_n) err <= 1'b0;
    else if (!abort) err <= accept ? 1'b0 : err | wdt_hit;
  end
`else
  logic wdt_hit;
  assign wdt_hit = 1'b0;
  assign err = 1'b0;
`endif
  always_comb begin
    next = state;
    unique case (state)
      IDLE:       if (start_pulse) next = SCORE_GO;
      SCORE_GO:   next = SCORE_WAIT;
      SCORE_WAIT: if (score_done) next = LD_ADDR;
      LD_ADDR:    next = LD_CAP;
      LD_CAP:     next = last_idx ? SCALE_GO : LD_ADDR;
      SCALE_GO:   next = SCALE_WAIT;
      SCALE_WAIT: if (scale_done) next = SM_GO;
      SM_GO:      next = SM_FEED;
      SM_FEED:    if (col == 2'd3) next = SM_WAIT;
      SM_WAIT:    if ((mask | sm_done) == 4'hF) next = GEMM_GO;
      GEMM_GO:    next = GEMM_WAIT;
      GEMM_WAIT:  if (gemm_done) next = NEXT_HEAD;
      NEXT_HEAD:  next = last_head ? DONE : LD_ADDR;
      DONE:       next = IDLE;
      default:    next = IDLE;
    endcase
    if (wdt_hit) next = DONE;
    if (abort) next = IDLE;
  end
  always_comb begin
    cap_nx = cap;
    cap_nx[idx*SCORE_W +: SCORE_W] = score_rd_data;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      start_d <= 1'b0;
      head_sel <= '0;
      idx <= '0;
      col <= '0;
      mask <= '0;
      cap <= '0;
      score_head_flat <= '0;
    end else begin
      state <= next;
      start_d <= start;
      idx <= state == LD_CAP ? idx + 4'd1 : state == LD_ADDR ? idx : 4'd0;
      col <= state == SM_FEED ? col + 2'd1 : 2'd0;
      mask <= state == SM_FEED || state == SM_WAIT ? mask | sm_done : 4'd0;
      if (accept) head_sel <= '0;
      else if (state == NEXT_HEAD && next == LD_ADDR) head_sel <= head_sel + 1'b1;
      if (state == LD_CAP) cap <= cap_nx;
      if (next == SCALE_GO) score_head_flat <= cap_nx;
    end
  end
  assign score_start = state == SCORE_GO;
  assign score_rd_en = state == LD_ADDR;
  assign score_rd_addr = score_rd_en ? {head_sel, idx} : '0;
  assign scale_start = state == SCALE_GO || state == SCALE_WAIT;
  assign sm_start = state == SM_GO;
  assign sm_feed = state == SM_FEED;
  assign sm_col = sm_feed ? col : 2'd0;
  assign gemm_start = state == GEMM_GO;
  assign busy = state != IDLE;
  assign done = state == DONE;
endmodule

// File: tb/tb_attn_head_sched.sv
// tb_attn_head_sched: directed bench with behavioural score/scale/softmax/GEMM engines and a regfile.
module tb_attn_head_sched;
  logic clk = 0, rst_n = 0, start = 0, abort = 0;
  logic score_start, score_rd_en, scale_start, sm_start, sm_feed, gemm_start, busy, done, err;
  logic score_done = 0, scale_done = 0, gemm_done = 0;
  logic [5:0] score_rd_addr;
  logic [31:0] score_rd_data = 0;
  logic [511:0] score_head_flat;
  logic [1:0] sm_col, head_sel;
  logic [3:0] sm_done = 0;

  attn_head_sched #(.NUM_HEADS(4), .SCORES_PER_HEAD(16), .TIMEOUT(64)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .score_start(score_start), .score_done(score_done),
    .score_rd_en(score_rd_en), .score_rd_addr(score_rd_addr), .score_rd_data(score_rd_data),
    .scale_start(scale_start), .scale_done(scale_done), .score_head_flat(score_head_flat),
    .sm_start(sm_start), .sm_col(sm_col), .sm_feed(sm_feed), .sm_done(sm_done),
    .gemm_start(gemm_start), .gemm_done(gemm_done),
    .head_sel(head_sel), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_checks = 0, n_fail = 0;
  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // engine models: completion pulses scheduled relative to the start strobe cycle
  int dly[4] = '{6, 6, 6, 6};
  bit scale_en = 1;
  int sc_t = -1, sl_t = -1, gm_t = -1;
  int sm_t[4] = '{-1, -1, -1, -1};
  logic sl_prev = 0;
  always @(negedge clk) begin
    score_done = cyc == sc_t;
    scale_done = cyc == sl_t;
    gemm_done = cyc == gm_t;
    for (int r = 0; r < 4; r++) sm_done[r] = cyc == sm_t[r];
    if (score_start === 1'b1) sc_t = cyc + 5;
    if (scale_start === 1'b1 && sl_prev !== 1'b1 && scale_en) sl_t = cyc + 3;
    sl_prev = scale_start;
    if (gemm_start === 1'b1) gm_t = cyc + 10;
    if (sm_start === 1'b1) for (int r = 0; r < 4; r++) sm_t[r] = cyc + dly[r];
    if (score_rd_en === 1'b1) score_rd_data = 32'(score_rd_addr) * 32'h11;
  end

  int n_score = 0, n_done = 0, t_score = 0, t_done = 0, t_sm = 0, t_ld = 0, t_sg = 0;
  int heads[$], gaps[$], ldsg[$];
  logic err_done = 0, done_prev = 0, mon_sl = 0;
  logic [511:0] flat2 = 0;
  always @(negedge clk) begin
    if (done_prev === 1'b1) chk("busy_after_done", {busy, done}, 0);
    if (score_start === 1'b1) begin n_score++; t_score = cyc; end
    if (sm_start === 1'b1) t_sm = cyc;
    if (gemm_start === 1'b1) begin heads.push_back(int'(head_sel)); gaps.push_back(cyc - t_sm); end
    if (score_rd_en === 1'b1 && score_rd_addr[3:0] == 4'd0) t_ld = cyc;
    if (scale_start === 1'b1 && mon_sl !== 1'b1) begin
      t_sg = cyc;
      ldsg.push_back(cyc - t_ld);
      if (head_sel == 2'd2) flat2 = score_head_flat;
    end
    if (done === 1'b1) begin
      n_done++;
      t_done = cyc;
      err_done = err;
      chk("busy_with_done", busy, 1);
    end
    done_prev = done;
    mon_sl = scale_start;
  end

  task automatic clr();
    n_score = 0; n_done = 0;
    heads.delete(); gaps.delete(); ldsg.delete();
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1;
    @(negedge clk) start = 0;
  endtask

  task automatic wait_done(input int limit);
    int d0 = n_done;
    int i = 0;
    while (n_done == d0 && i < limit) begin @(negedge clk); i++; end
    chk("done_timeout", n_done != d0, 1);
  endtask

  typedef struct { int d0, d1, d2, d3, gap, len; } vec_t;
  vec_t tbl[4];

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "bench stalled");
  end

  initial begin
    // softmax row delays from sm_start; gap = sm_start->gemm_start; len = score_start->done
    tbl[0] = '{6, 6, 6, 6, 7, 226};
    tbl[1] = '{2, 7, 12, 14, 15, 258};
    tbl[2] = '{1, 2, 3, 4, 6, 222};
    tbl[3] = '{9, 3, 20, 1, 21, 282};
    repeat (3) @(negedge clk);
    chk("rst_outs", {score_start, score_rd_en, score_rd_addr, scale_start, sm_start, sm_col,
                     sm_feed, gemm_start, head_sel, busy, done, err}, 0);
    chk("rst_flat", |score_head_flat, 0);
    rst_n = 1;
    for (int v = 0; v < 4; v++) begin
      dly = '{tbl[v].d0, tbl[v].d1, tbl[v].d2, tbl[v].d3};
      clr();
      pulse_start();
      wait_done(600);
      repeat (3) @(negedge clk);
      chk($sformatf("v%0d_score_starts", v), n_score, 1);
      chk($sformatf("v%0d_dones", v), n_done, 1);
      chk($sformatf("v%0d_gemm_starts", v), heads.size(), 4);
      foreach (heads[h]) chk($sformatf("v%0d_head_sel%0d", v, h), heads[h], h);
      foreach (gaps[h]) chk($sformatf("v%0d_sm_gap%0d", v, h), gaps[h], tbl[v].gap);
      foreach (ldsg[h]) chk($sformatf("v%0d_readout_len%0d", v, h), ldsg[h], 32);
      chk($sformatf("v%0d_run_len", v), t_done - t_score, tbl[v].len);
      chk($sformatf("v%0d_err", v), err_done, 0);
      if (v == 0)
        for (int i = 0; i < 16; i++) chk($sformatf("head2_word%0d", i), flat2[i*32 +: 32], (32 + i) * 17);
    end
    // abort during head 1 GEMM_WAIT, then a clean rerun
    dly = '{6, 6, 6, 6};
    clr();
    pulse_start();
    for (int i = 0; i < 400 && heads.size() < 2; i++) @(negedge clk);
    chk("abort_reach_h1", heads.size(), 2);
    @(negedge clk) abort = 1;
    @(negedge clk) abort = 0;
    chk("abort_idle", {busy, done, score_start, score_rd_en, scale_start, sm_start, sm_feed, gemm_start}, 0);
    repeat (20) @(negedge clk);
    chk("abort_no_done", n_done, 0);
    clr();
    pulse_start();
    wait_done(600);
    repeat (3) @(negedge clk);
    chk("rerun_score_starts", n_score, 1);
    chk("rerun_gemm_starts", heads.size(), 4);
    foreach (heads[h]) chk($sformatf("rerun_head_sel%0d", h), heads[h], h);
    // start held high across a whole run: rising edge only
    clr();
    @(negedge clk) start = 1;
    repeat (240) @(negedge clk);
    chk("held_score_starts", n_score, 1);
    chk("held_dones", n_done, 1);
    chk("held_idle", busy, 0);
    start = 0;
    // extra start pulses while busy are ignored
    clr();
    pulse_start();
    repeat (50) @(negedge clk);
    chk("busy_mid_run", busy, 1);
    pulse_start();
    repeat (30) @(negedge clk);
    pulse_start();
    wait_done(600);
    repeat (5) @(negedge clk);
    chk("extra_score_starts", n_score, 1);
    chk("extra_dones", n_done, 1);
    chk("extra_idle", busy, 0);
`ifdef ATTN_SCHED_WDT_EN
    scale_en = 0;
    clr();
    pulse_start();
    wait_done(400);
    chk("wdt_err_at_done", err_done, 1);
    chk("wdt_latency", t_done - t_sg, 65);
    repeat (5) @(negedge clk);
    chk("wdt_err_sticky", err, 1);
    scale_en = 1;
    clr();
    pulse_start();
    @(negedge clk);
    chk("wdt_err_clear", err, 0);
    wait_done(600);
    chk("wdt_rerun_err", err_done, 0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
